// File: rtl/prog_loader.sv
// Program-load front end: streams instruction words into an internal RAM while
// holding the core in reset, then serves fetch reads as an instruction ROM.
module prog_loader #(
  parameter int            IW        = 9,
  parameter int            AW        = 10,
  parameter int            DEPTH     = 1024,
  parameter logic [IW-1:0] FILL_WORD = 9'h1FF
) (
  input  logic          CLK,
  input  logic          start,
  input  logic          load_valid,
  input  logic [IW-1:0] load_word,
  input  logic          load_last,
  output logic          load_ready,
  input  logic [AW-1:0] InstAddress,
  output logic [IW-1:0] InstOut,
  output logic          core_reset,
  output logic [AW:0]   word_count,
  output logic          load_done,
  output logic          overflow
);

  localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    LOAD,
    RELEASE,
    RUN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          at_last_slot;
  logic [IW-1:0] mem [DEPTH];

  // word_count doubles as the write pointer: it never wraps, loading stops at DEPTH
  assign at_last_slot = (word_count == LAST_IDX);

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    core_reset = 1'b1;
    load_done  = 1'b0;
    accept     = 1'b0;
    case (state)
      LOAD: begin
        load_ready = 1'b1;
        accept     = load_valid;
        if (accept && (load_last || at_last_slot)) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = RUN;
      RUN: begin
        core_reset = 1'b0;
        load_done  = 1'b1;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      state      <= LOAD;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        word_count <= word_count + 1'b1;
        if (at_last_slot && !load_last) overflow <= 1'b1;
      end
    end
  end

  // RAM is never cleared; stale words stay hidden behind the word_count compare
  always_ff @(posedge CLK) begin
    if (accept && !start) mem[word_count[PW-1:0]] <= load_word;
  end

  assign InstOut = ({1'b0, InstAddress} < word_count) ? mem[InstAddress[PW-1:0]] : FILL_WORD;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader (DEPTH=8 so the overflow path is reachable):
// stimulus pushes the expected per-cycle outputs, a negedge monitor pops and compares.
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        start;
  logic        load_valid;
  logic [8:0]  load_word;
  logic        load_last;
  logic        load_ready;
  logic [9:0]  InstAddress;
  logic [8:0]  InstOut;
  logic        core_reset;
  logic [10:0] word_count;
  logic        load_done;
  logic        overflow;

  typedef struct {
    logic        rdy;
    logic        crst;
    logic        done;
    logic [10:0] cnt;
    logic        ovf;
    logic [8:0]  inst;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  prog_loader #(.IW(9), .AW(10), .DEPTH(8), .FILL_WORD(9'h1FF)) dut (
    .CLK        (CLK),
    .start      (start),
    .load_valid (load_valid),
    .load_word  (load_word),
    .load_last  (load_last),
    .load_ready (load_ready),
    .InstAddress(InstAddress),
    .InstOut    (InstOut),
    .core_reset (core_reset),
    .word_count (word_count),
    .load_done  (load_done),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string nm, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s.%s actual=%0h expected=%0h", nm, field, act, exp);
    end
  endtask

  // Drives one cycle of inputs just after a posedge and records what the outputs
  // must look like during that cycle (state from the posedge just taken).
  task automatic applyStimulus(input string nm, input logic st, input logic v,
                               input logic [8:0] w, input logic l, input logic [9:0] a,
                               input logic er, input logic ec, input logic ed,
                               input logic [10:0] ecnt, input logic eo,
                               input logic [8:0] ei);
    exp_t e;
    @(posedge CLK);
    #1;
    start       = st;
    load_valid  = v;
    load_word   = w;
    load_last   = l;
    InstAddress = a;
    e.rdy  = er;
    e.crst = ec;
    e.done = ed;
    e.cnt  = ecnt;
    e.ovf  = eo;
    e.inst = ei;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e.nm, "load_ready", 32'(load_ready), 32'(e.rdy));
        checkOutput(e.nm, "core_reset", 32'(core_reset), 32'(e.crst));
        checkOutput(e.nm, "load_done",  32'(load_done),  32'(e.done));
        checkOutput(e.nm, "word_count", 32'(word_count), 32'(e.cnt));
        checkOutput(e.nm, "overflow",   32'(overflow),   32'(e.ovf));
        checkOutput(e.nm, "InstOut",    32'(InstOut),    32'(e.inst));
      end
    end
  end

  initial begin : stimulus
    int budget;
    start       = 1'b1;
    load_valid  = 1'b0;
    load_word   = '0;
    load_last   = 1'b0;
    InstAddress = '0;

    // basic 3-word load, valid held high
    //             name        st   v    word    l    addr   rdy  crst done cnt  ovf  inst
    applyStimulus("rst_state", 0, 1, 9'h011, 0, 10'd0, 1, 1, 0, 11'd0, 0, 9'h1FF);
    applyStimulus("ld1_w1",    0, 1, 9'h022, 0, 10'd0, 1, 1, 0, 11'd1, 0, 9'h011);
    applyStimulus("ld1_w2",    0, 1, 9'h133, 1, 10'd1, 1, 1, 0, 11'd2, 0, 9'h022);
    applyStimulus("ld1_rel",   0, 0, 9'h000, 0, 10'd2, 0, 1, 0, 11'd3, 0, 9'h133);
    applyStimulus("ld1_run3",  0, 0, 9'h000, 0, 10'd3, 0, 0, 1, 11'd3, 0, 9'h1FF);
    applyStimulus("ld1_run0",  0, 0, 9'h000, 0, 10'd0, 0, 0, 1, 11'd3, 0, 9'h011);

    // load_valid ignored in RUN
    for (int i = 0; i < 5; i++) begin
      logic [9:0] a;
      logic [8:0] exp_i;
      a = 10'(i % 4);
      case (i % 4)
        0: exp_i = 9'h011;
        1: exp_i = 9'h022;
        2: exp_i = 9'h133;
        default: exp_i = 9'h1FF;
      endcase
      applyStimulus("run_ignore", 0, 1, 9'h0AA, 1, a, 0, 0, 1, 11'd3, 0, exp_i);
    end

    // reload with load_valid toggling; stale words stay masked
    applyStimulus("ld2_rst",  1, 0, 9'h000, 0, 10'd0, 0, 0, 1, 11'd3, 0, 9'h011);
    applyStimulus("ld2_v1",   0, 1, 9'h011, 0, 10'd0, 1, 1, 0, 11'd0, 0, 9'h1FF);
    applyStimulus("ld2_v0a",  0, 0, 9'h000, 0, 10'd0, 1, 1, 0, 11'd1, 0, 9'h011);
    applyStimulus("ld2_v1b",  0, 1, 9'h022, 0, 10'd1, 1, 1, 0, 11'd1, 0, 9'h1FF);
    applyStimulus("ld2_v0b",  0, 0, 9'h000, 0, 10'd1, 1, 1, 0, 11'd2, 0, 9'h022);
    applyStimulus("ld2_v1c",  0, 1, 9'h133, 1, 10'd2, 1, 1, 0, 11'd2, 0, 9'h1FF);
    applyStimulus("ld2_rel",  0, 0, 9'h000, 0, 10'd2, 0, 1, 0, 11'd3, 0, 9'h133);
    applyStimulus("ld2_run",  0, 0, 9'h000, 0, 10'd3, 0, 0, 1, 11'd3, 0, 9'h1FF);

    // fill all 8 slots without load_last -> overflow
    applyStimulus("ovf_rst",  1, 0, 9'h000, 0, 10'd0, 0, 0, 1, 11'd3, 0, 9'h011);
    for (int i = 0; i < 8; i++) begin
      logic [9:0] a;
      logic [8:0] exp_i;
      a     = (i == 0) ? 10'd0 : 10'(i - 1);
      exp_i = (i == 0) ? 9'h1FF : 9'(9'h0C0 + i - 1);
      applyStimulus("ovf_fill", 0, 1, 9'(9'h0C0 + i), 0, a, 1, 1, 0, 11'(i), 0, exp_i);
    end
    applyStimulus("ovf_rel",  0, 0, 9'h000, 0, 10'd7, 0, 1, 0, 11'd8, 1, 9'h0C7);
    applyStimulus("ovf_run8", 0, 1, 9'h0AA, 0, 10'd8, 0, 0, 1, 11'd8, 1, 9'h1FF);
    applyStimulus("ovf_run0", 0, 0, 9'h000, 0, 10'd0, 0, 0, 1, 11'd8, 1, 9'h0C0);

    // reset after 2 of 4 words, then a 1-word reload
    applyStimulus("mid_rst",  1, 0, 9'h000, 0, 10'd0, 0, 0, 1, 11'd8, 1, 9'h0C0);
    applyStimulus("mid_w0",   0, 1, 9'h0E1, 0, 10'd0, 1, 1, 0, 11'd0, 0, 9'h1FF);
    applyStimulus("mid_w1",   0, 1, 9'h0E2, 0, 10'd0, 1, 1, 0, 11'd1, 0, 9'h0E1);
    applyStimulus("mid_abort",1, 0, 9'h000, 0, 10'd1, 1, 1, 0, 11'd2, 0, 9'h0E2);
    applyStimulus("mid_rl",   0, 1, 9'h055, 1, 10'd0, 1, 1, 0, 11'd0, 0, 9'h1FF);
    applyStimulus("mid_rel",  0, 0, 9'h000, 0, 10'd0, 0, 1, 0, 11'd1, 0, 9'h055);
    applyStimulus("mid_run1", 0, 0, 9'h000, 0, 10'd1, 0, 0, 1, 11'd1, 0, 9'h1FF);

    // start wins over an accept in the same cycle
    applyStimulus("pri_rst",  1, 0, 9'h000, 0, 10'd0, 0, 0, 1, 11'd1, 0, 9'h055);
    applyStimulus("pri_both", 1, 1, 9'h0AB, 1, 10'd0, 1, 1, 0, 11'd0, 0, 9'h1FF);
    applyStimulus("pri_after",0, 0, 9'h000, 0, 10'd0, 1, 1, 0, 11'd0, 0, 9'h1FF);
    applyStimulus("pri_ld",   0, 1, 9'h0CD, 0, 10'd0, 1, 1, 0, 11'd0, 0, 9'h1FF);
    applyStimulus("pri_ld2",  0, 1, 9'h0CE, 1, 10'd0, 1, 1, 0, 11'd1, 0, 9'h0CD);
    applyStimulus("pri_rel",  0, 0, 9'h000, 0, 10'd1, 0, 1, 0, 11'd2, 0, 9'h0CE);
    applyStimulus("pri_run",  0, 0, 9'h000, 0, 10'd2, 0, 0, 1, 11'd2, 0, 9'h1FF);

    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge CLK);
      budget--;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program-load front end that sits directly upstream of the instruction fetch path.
- Accepts 9-bit instruction words over a valid/ready stream and writes them sequentially into an internal instruction RAM.
- Holds the core in reset while loading, then releases it.
- Serves the PC's fetch address with a combinational read, as a drop-in replacement for the instruction ROM. Addresses past the loaded program return a fixed fill word.

Parameters:
- IW, 9, instruction word width.
- AW, 10, instruction address width (matches PC width).
- DEPTH, 1024, RAM depth in words (DEPTH <= 2**AW).
- FILL_WORD, 9'h1FF, value returned for addresses >= word_count.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- start  input  1  reset; synchronous, active-high.
- load_valid  input  1  a load word is presented this cycle.
- load_word  input  IW  instruction word being loaded.
- load_last  input  1  qualifies load_word as the final program word.
- load_ready  output  1  loader accepts a word this cycle.
- InstAddress  input  AW  fetch address from the PC.
- InstOut  output  IW  instruction at InstAddress; combinational.
- core_reset  output  1  held high to keep the core (PC, cycle counter) in reset.
- word_count  output  AW+1  number of words loaded so far.
- load_done  output  1  program load complete; core running.
- overflow  output  1  sticky; load ended by hitting DEPTH without load_last.

Behaviour:
- FSM states: LOAD, RELEASE, RUN.
- Reset (start=1 at posedge):
  - state <= LOAD; wr_ptr <= 0; word_count <= 0; overflow <= 0.
  - RAM contents are NOT cleared; stale data is masked by the word_count compare.
- LOAD:
  - load_ready=1, core_reset=1, load_done=0.
  - A word is accepted when load_valid & load_ready at posedge: mem[wr_ptr] <= load_word; wr_ptr and word_count increment by 1.
  - Accepted with load_last=1 -> next state RELEASE.
  - Accepted with wr_ptr==DEPTH-1 and load_last=0 -> treated as last: overflow <= 1, next state RELEASE.
  - No acceptance -> stay in LOAD.
- RELEASE:
  - Lasts exactly 1 cycle, with load_ready=0, core_reset=1, load_done=0.
  - Next state RUN. This gives the core one full reset cycle after the last write is visible.
- RUN:
  - load_ready=0, core_reset=0, load_done=1.
  - load_valid is ignored and nothing is written.
  - Stays in RUN until start.
- Output values in state LOAD (including immediately after reset): load_ready=1, core_reset=1, load_done=0, word_count=0, overflow=0.
- Read path, valid in all states:
  - InstOut = mem[InstAddress] if InstAddress < word_count, else FILL_WORD.
  - Compare is unsigned, width AW+1.
  - A word written at posedge N is readable combinationally from cycle N+1 onward.
  - During LOAD, a read of the address being written this cycle returns the fill/old value; there is no write-to-read bypass.
- Zero-length program:
  - Not expressible, because load_last always accompanies a word.
  - word_count is 1..DEPTH after any completed load.
- Simultaneous events:
  - start=1 has priority over any accept. A word presented in the reset cycle is dropped and does not advance wr_ptr.
- Reset mid-load:
  - word_count returns to 0, so previously written words become masked (read as FILL_WORD).
  - The next load overwrites from address 0.
- word_count saturates at DEPTH; wr_ptr never wraps.

Test Plan:
- Load 3 words 9'h011, 9'h022, 9'h133 (last on the third), load_valid held high -> load_ready high 3 cycles, RELEASE 1 cycle with core_reset=1, then load_done=1, core_reset=0, word_count=3; InstAddress=0,1,2,3 -> 011, 022, 133, 1FF.
- Same load with load_valid toggling 1,0,1,0,1 -> only 3 writes occur; same final contents; word_count steps 0->1->1->2->2->3.
- DEPTH=8 override, 8 words with load_last never set -> overflow=1 after the 8th accept, RELEASE then RUN, word_count=8, address 7 returns the 8th word.
- In RUN, drive load_valid=1 with word 9'h0AA for 5 cycles -> load_ready=0, memory unchanged, word_count stays 3.
- Reset mid-load after 2 of 4 words -> word_count=0, address 0 reads 1FF; reload 1 word 9'h055 with last -> address 0=055, address 1=1FF.
- Assert start in the same cycle as an accepted word in LOAD -> word not written, wr_ptr=0, word_count=0 next cycle.
